// File: rtl/riscv_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path.
// MULTICYCLE_CTRL_ILLEGAL_TRAP_EN adds the TRAP state to ctrl_state_e.
package riscv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        ,
        TRAP   = 3'd6
`endif
    } ctrl_state_e;

    // Separate constants per opcode: the I/U groupings merge classes we must tell apart.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_e;

    typedef enum logic [3:0] {
        CLS_LOAD   = 4'd0,
        CLS_STORE  = 4'd1,
        CLS_BRANCH = 4'd2,
        CLS_JAL    = 4'd3,
        CLS_JALR   = 4'd4,
        CLS_OP     = 4'd5,
        CLS_OPIMM  = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_AUIPC  = 4'd8
    } op_class_e;

    function automatic logic alu_b_uses_imm(input op_class_e cls);
        return (cls == CLS_OPIMM) || (cls == CLS_LOAD) || (cls == CLS_STORE) ||
               (cls == CLS_JALR)  || (cls == CLS_AUIPC);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_opclass.sv
// Combinational opcode classifier: op_i -> instruction class plus legal flag.
module multicycle_ctrl_opclass
    import riscv_pkg::*;
(
    input  logic [6:0] op_i,
    output op_class_e  cls_o,
    output logic       legal_o
);

    // Map each supported opcode to its class; anything else is illegal.
    always_comb begin
        cls_o   = CLS_OP;
        legal_o = 1'b1;
        case (op_i)
            OPC_LOAD:   cls_o = CLS_LOAD;
            OPC_STORE:  cls_o = CLS_STORE;
            OPC_BRANCH: cls_o = CLS_BRANCH;
            OPC_JAL:    cls_o = CLS_JAL;
            OPC_JALR:   cls_o = CLS_JALR;
            OPC_OP:     cls_o = CLS_OP;
            OPC_OPIMM:  cls_o = CLS_OPIMM;
            OPC_LUI:    cls_o = CLS_LUI;
            OPC_AUIPC:  cls_o = CLS_AUIPC;
            default:    legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core (fetch/decode/exec/mem/wb).
// Optional: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN traps illegal opcodes and adds illegal_o.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter bit RESET_STATE_FETCH = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [6:0] op_i,
    input  logic       branch_taken_i,
    output logic       imem_req_o,
    input  logic       imem_rvalid_i,
    output logic       dmem_req_o,
    output logic       dmem_we_o,
    input  logic       dmem_rvalid_i,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic [1:0] pc_sel_o,
    output logic       alu_a_sel_o,
    output logic       alu_b_sel_o,
    output logic       rf_we_o,
    output logic [1:0] wb_sel_o,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    output logic [2:0] state_o,
    output logic       illegal_o
`else
    output logic [2:0] state_o
`endif
);

    localparam ctrl_state_e RESET_STATE = RESET_STATE_FETCH ? FETCH : IDLE;

    ctrl_state_e state_r, next_state_s;
    op_class_e   cls_r, cls_s;
    logic        legal_s, cls_we_s;
    logic        imem_req_s, dmem_req_s, dmem_we_s, ir_we_s, pc_we_s;
    logic        alu_a_sel_s, alu_b_sel_s, rf_we_s;
    pc_sel_e     pc_sel_s;
    wb_sel_e     wb_sel_s;

    multicycle_ctrl_opclass u_opclass (
        .op_i    (op_i),
        .cls_o   (cls_s),
        .legal_o (legal_s)
    );

    // Next-state and control decode; everything is forced low while rst_ni is asserted.
    always_comb begin
        next_state_s = state_r;
        cls_we_s     = 1'b0;
        imem_req_s   = 1'b0;
        dmem_req_s   = 1'b0;
        dmem_we_s    = 1'b0;
        ir_we_s      = 1'b0;
        pc_we_s      = 1'b0;
        pc_sel_s     = PC_PLUS4;
        alu_a_sel_s  = 1'b0;
        alu_b_sel_s  = 1'b0;
        rf_we_s      = 1'b0;
        wb_sel_s     = WB_ALU;
        if (rst_ni) begin
            case (state_r)
                IDLE: begin
                    if (start_i) next_state_s = FETCH;
                    else         next_state_s = IDLE;
                end
                FETCH: begin
                    imem_req_s = 1'b1;
                    if (imem_rvalid_i) begin
                        ir_we_s      = 1'b1;
                        next_state_s = DECODE;
                    end else begin
                        next_state_s = FETCH;
                    end
                end
                DECODE: begin
                    if (legal_s) begin
                        cls_we_s     = 1'b1;
                        next_state_s = EXEC;
                    end else begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                        next_state_s = TRAP;
`else
                        pc_we_s      = 1'b1;
                        pc_sel_s     = PC_PLUS4;
                        next_state_s = FETCH;
`endif
                    end
                end
                EXEC: begin
                    if (cls_r == CLS_BRANCH) begin
                        pc_we_s      = 1'b1;
                        pc_sel_s     = branch_taken_i ? PC_IMM : PC_PLUS4;
                        next_state_s = FETCH;
                    end else if ((cls_r == CLS_LOAD) || (cls_r == CLS_STORE)) begin
                        next_state_s = MEM;
                    end else begin
                        next_state_s = WB;
                    end
                end
                MEM: begin
                    dmem_req_s = 1'b1;
                    dmem_we_s  = (cls_r == CLS_STORE);
                    if (!dmem_rvalid_i) begin
                        next_state_s = MEM;
                    end else if (cls_r == CLS_STORE) begin
                        pc_we_s      = 1'b1;
                        pc_sel_s     = PC_PLUS4;
                        next_state_s = FETCH;
                    end else begin
                        next_state_s = WB;
                    end
                end
                WB: begin
                    rf_we_s      = 1'b1;
                    pc_we_s      = 1'b1;
                    next_state_s = FETCH;
                    case (cls_r)
                        CLS_LOAD: begin wb_sel_s = WB_LOAD; pc_sel_s = PC_PLUS4; end
                        CLS_JAL:  begin wb_sel_s = WB_PC4;  pc_sel_s = PC_IMM;   end
                        CLS_JALR: begin wb_sel_s = WB_PC4;  pc_sel_s = PC_ALU;   end
                        CLS_LUI:  begin wb_sel_s = WB_IMM;  pc_sel_s = PC_PLUS4; end
                        default:  begin wb_sel_s = WB_ALU;  pc_sel_s = PC_PLUS4; end
                    endcase
                end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                TRAP: next_state_s = TRAP;
`endif
                default: next_state_s = RESET_STATE;
            endcase
            // ALU operand selects stay stable from EXEC until the instruction retires.
            if ((state_r == EXEC) || (state_r == MEM) || (state_r == WB)) begin
                alu_a_sel_s = (cls_r == CLS_AUIPC);
                alu_b_sel_s = alu_b_uses_imm(cls_r);
            end else begin
                alu_a_sel_s = 1'b0;
                alu_b_sel_s = 1'b0;
            end
        end else begin
            next_state_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_r <= RESET_STATE;
        else         state_r <= next_state_s;
    end

    // Instruction class captured in DECODE so later op_i changes are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       cls_r <= CLS_OP;
        else if (cls_we_s) cls_r <= cls_s;
        else               cls_r <= cls_r;
    end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic illegal_r;

    // Sticky illegal flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                    illegal_r <= 1'b0;
        else if (next_state_s == TRAP)  illegal_r <= 1'b1;
        else                            illegal_r <= illegal_r;
    end

    assign illegal_o = illegal_r;
`endif

    assign imem_req_o  = imem_req_s;
    assign dmem_req_o  = dmem_req_s;
    assign dmem_we_o   = dmem_we_s;
    assign ir_we_o     = ir_we_s;
    assign pc_we_o     = pc_we_s;
    assign pc_sel_o    = pc_sel_s;
    assign alu_a_sel_o = alu_a_sel_s;
    assign alu_b_sel_o = alu_b_sel_s;
    assign rf_we_o     = rf_we_s;
    assign wb_sel_o    = wb_sel_s;
    assign state_o     = rst_ni ? state_r : 3'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level reference model, random don't-care inputs.
module tb_multicycle_ctrl;
    import riscv_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic [6:0] op_i = 7'd0;
    logic       branch_taken_i = 1'b0;
    logic       imem_rvalid_i = 1'b0;
    logic       dmem_rvalid_i = 1'b0;
    logic       imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o;
    logic [1:0] pc_sel_o, wb_sel_o;
    logic       alu_a_sel_o, alu_b_sel_o, rf_we_o;
    logic [2:0] state_o;
    logic       ill_w;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [6:0]  op;
        logic        taken;
        logic        irv;
        logic        drv;
        logic [15:0] exp;
    } cyc_t;

    cyc_t trace[$];

    always #5 clk = ~clk;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic illegal_o;
    assign ill_w = illegal_o;
`else
    assign ill_w = 1'b0;
`endif

    multicycle_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .op_i           (op_i),
        .branch_taken_i (branch_taken_i),
        .imem_req_o     (imem_req_o),
        .imem_rvalid_i  (imem_rvalid_i),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .ir_we_o        (ir_we_o),
        .pc_we_o        (pc_we_o),
        .pc_sel_o       (pc_sel_o),
        .alu_a_sel_o    (alu_a_sel_o),
        .alu_b_sel_o    (alu_b_sel_o),
        .rf_we_o        (rf_we_o),
        .wb_sel_o       (wb_sel_o),
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        .state_o        (state_o),
        .illegal_o      (illegal_o)
`else
        .state_o        (state_o)
`endif
    );

    function automatic logic [15:0] pk(bit ireq, bit dreq, bit dwe, bit irwe, bit pcwe,
                                       logic [1:0] pcs, bit aa, bit ab, bit rfwe,
                                       logic [1:0] wbs, ctrl_state_e st, bit ill);
        return {ill, ireq, dreq, dwe, irwe, pcwe, pcs, aa, ab, rfwe, wbs, st};
    endfunction

    function automatic logic [15:0] observed();
        return {ill_w, imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o,
                alu_a_sel_o, alu_b_sel_o, rf_we_o, wb_sel_o, state_o};
    endfunction

    function automatic cyc_t rnd_cyc();
        cyc_t c;
        c.op    = 7'($urandom);
        c.taken = 1'($urandom);
        c.irv   = 1'($urandom);
        c.drv   = 1'($urandom);
        c.exp   = 16'd0;
        return c;
    endfunction

    // Reference model: expand one instruction into its expected per-cycle behaviour.
    function automatic void build(input logic [6:0] op, input int fd, input int md, input bit taken);
        cyc_t c;
        bit ld, st, br, legal, aa, ab;
        logic [1:0] wbs, pcs;
        ld    = (op == OPC_LOAD);
        st    = (op == OPC_STORE);
        br    = (op == OPC_BRANCH);
        legal = op inside {OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
                           OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC};
        aa    = (op == OPC_AUIPC);
        ab    = op inside {OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_JALR, OPC_AUIPC};
        for (int i = 0; i <= fd; i++) begin
            c = rnd_cyc();
            c.irv = (i == fd);
            c.exp = pk(1, 0, 0, (i == fd), 0, 2'd0, 0, 0, 0, 2'd0, FETCH, 0);
            trace.push_back(c);
        end
        c = rnd_cyc();
        c.op = op;
        if (!legal) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            c.exp = pk(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, DECODE, 0);
`else
            c.exp = pk(0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 2'd0, DECODE, 0);
`endif
            trace.push_back(c);
            return;
        end
        c.exp = pk(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, DECODE, 0);
        trace.push_back(c);
        c = rnd_cyc();
        if (br) begin
            c.taken = taken;
            c.exp = pk(0, 0, 0, 0, 1, {1'b0, taken}, 0, 0, 0, 2'd0, EXEC, 0);
            trace.push_back(c);
            return;
        end
        c.exp = pk(0, 0, 0, 0, 0, 2'd0, aa, ab, 0, 2'd0, EXEC, 0);
        trace.push_back(c);
        if (ld || st) begin
            for (int i = 0; i <= md; i++) begin
                c = rnd_cyc();
                c.drv = (i == md);
                c.exp = pk(0, 1, st, 0, (st && i == md), 2'd0, aa, ab, 0, 2'd0, MEM, 0);
                trace.push_back(c);
            end
            if (st) return;
        end
        wbs = ld ? 2'd1 : (op == OPC_JAL || op == OPC_JALR) ? 2'd2 : (op == OPC_LUI) ? 2'd3 : 2'd0;
        pcs = (op == OPC_JAL) ? 2'd1 : (op == OPC_JALR) ? 2'd2 : 2'd0;
        c = rnd_cyc();
        c.exp = pk(0, 0, 0, 0, 1, pcs, aa, ab, 1, wbs, WB, 0);
        trace.push_back(c);
    endfunction

    // Apply one cycle of inputs (called just after a falling edge) and return the outputs seen.
    task automatic drive(input cyc_t c, output logic [15:0] obs);
        op_i           = c.op;
        branch_taken_i = c.taken;
        imem_rvalid_i  = c.irv;
        dmem_rvalid_i  = c.drv;
        #1;
        obs = observed();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        imem_rvalid_i = 1'b1;
        dmem_rvalid_i = 1'b1;
        #1;
        obs = observed();
        n_cmp++;
        if (obs !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_outputs act=%h exp=%h", obs, 16'h0000);
        end
        @(negedge clk);
        imem_rvalid_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        rst_ni = 1'b1;
        #1;
        obs = observed();
        n_cmp++;
        if (obs !== pk(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, FETCH, 0)) begin
            n_err++;
            $display("FAIL reset_release act=%h exp=%h", obs,
                     pk(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, FETCH, 0));
        end
        @(negedge clk);
    endtask

    task automatic test_addi();
        cyc_t c;
        logic [15:0] obs;
        int k = 0;
        build(OPC_OPIMM, 0, 0, 1'b0);
        while (trace.size() > 0) begin
            c = trace.pop_front();
            drive(c, obs);
            n_cmp++;
            if (obs !== c.exp) begin
                n_err++;
                $display("FAIL addi cyc%0d act=%h exp=%h", k, obs, c.exp);
            end
            k++;
        end
    endtask

    task automatic test_lw_wait();
        cyc_t c;
        logic [15:0] obs;
        int k = 0;
        build(OPC_LOAD, 0, 3, 1'b0);
        while (trace.size() > 0) begin
            c = trace.pop_front();
            drive(c, obs);
            n_cmp++;
            if (obs !== c.exp) begin
                n_err++;
                $display("FAIL lw_wait cyc%0d act=%h exp=%h", k, obs, c.exp);
            end
            k++;
        end
    endtask

    task automatic test_branch();
        cyc_t c;
        logic [15:0] obs;
        int k = 0;
        build(OPC_BRANCH, 0, 0, 1'b1);
        build(OPC_BRANCH, 1, 0, 1'b0);
        while (trace.size() > 0) begin
            c = trace.pop_front();
            drive(c, obs);
            n_cmp++;
            if (obs !== c.exp) begin
                n_err++;
                $display("FAIL branch cyc%0d act=%h exp=%h", k, obs, c.exp);
            end
            k++;
        end
    endtask

    task automatic test_jalr();
        cyc_t c;
        logic [15:0] obs;
        int k = 0;
        build(OPC_JALR, 0, 0, 1'b0);
        build(OPC_STORE, 0, 0, 1'b0);
        while (trace.size() > 0) begin
            c = trace.pop_front();
            drive(c, obs);
            n_cmp++;
            if (obs !== c.exp) begin
                n_err++;
                $display("FAIL jalr_store cyc%0d act=%h exp=%h", k, obs, c.exp);
            end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        cyc_t c;
        logic [15:0] obs;
        logic [6:0] legal_ops[9] = '{OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
                                     OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC};
        logic [6:0] bad_ops[4] = '{7'h7f, 7'h00, 7'h73, 7'h0f};
        logic [6:0] op;
        int k = 0;
        for (int n = 0; n < 150; n++) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            op = legal_ops[$urandom_range(0, 8)];
`else
            if ($urandom_range(0, 7) == 0) op = bad_ops[$urandom_range(0, 3)];
            else                           op = legal_ops[$urandom_range(0, 8)];
`endif
            build(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
            while (trace.size() > 0) begin
                c = trace.pop_front();
                drive(c, obs);
                n_cmp++;
                if (obs !== c.exp) begin
                    n_err++;
                    $display("FAIL random instr%0d op=%b cyc%0d act=%h exp=%h", n, op, k, obs, c.exp);
                end
                k++;
            end
        end
    endtask

    task automatic test_illegal();
        cyc_t c;
        logic [15:0] obs;
        int k = 0;
        build(7'h7f, 0, 0, 1'b0);
        while (trace.size() > 0) begin
            c = trace.pop_front();
            drive(c, obs);
            n_cmp++;
            if (obs !== c.exp) begin
                n_err++;
                $display("FAIL illegal cyc%0d act=%h exp=%h", k, obs, c.exp);
            end
            k++;
        end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 12; i++) begin
            c = rnd_cyc();
            drive(c, obs);
            n_cmp++;
            if (obs !== pk(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, TRAP, 1)) begin
                n_err++;
                $display("FAIL trap_hold cyc%0d act=%h exp=%h", i, obs,
                         pk(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, TRAP, 1));
            end
        end
`endif
    endtask

    task automatic test_reset_mid_mem();
        cyc_t c;
        logic [15:0] obs;
        int k = 0;
        build(OPC_LOAD, 0, 5, 1'b0);
        while (k < 4) begin
            c = trace.pop_front();
            drive(c, obs);
            n_cmp++;
            if (obs !== c.exp) begin
                n_err++;
                $display("FAIL rst_mem_pre cyc%0d act=%h exp=%h", k, obs, c.exp);
            end
            k++;
        end
        trace.delete();
        dmem_rvalid_i = 1'b0;
        #1;
        obs = observed();
        n_cmp++;
        if (obs[14:0] !== pk(0, 1, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, MEM, 0) >> 0 & 16'h7fff) begin
            n_err++;
            $display("FAIL rst_mem_req act=%h exp=%h", obs,
                     pk(0, 1, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, MEM, 0));
        end
        rst_ni = 1'b0;
        #1;
        obs = observed();
        n_cmp++;
        if (obs !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_mem_drop act=%h exp=%h", obs, 16'h0000);
        end
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        imem_rvalid_i = 1'b0;
        #1;
        obs = observed();
        n_cmp++;
        if (obs !== pk(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, FETCH, 0)) begin
            n_err++;
            $display("FAIL rst_mem_after act=%h exp=%h", obs,
                     pk(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, FETCH, 0));
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lw_wait();
        test_branch();
        test_jalr();
        test_back_to_back();
        test_illegal();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
